// File: rtl/instr_encoder.sv
// MIPS instruction encoder: mnemonic + fields -> 32-bit word, queued with an address tag.
// Optional branch delay-slot NOP insertion is enabled by defining ENC_DELAY_SLOT_EN.
module instr_encoder #(
    parameter int unsigned   DEPTH     = 4,
    parameter int unsigned   AW        = 8,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_mnem,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [31:0]   out_word,
    output logic          illegal,
    output logic [7:0]    illegal_count,
    input  logic          restart,
    output logic          busy
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

`ifdef ENC_DELAY_SLOT_EN
    typedef enum logic [1:0] {StRun, StPad, StDrain} state_e;
`else
    typedef enum logic [1:0] {StRun, StDrain} state_e;
`endif

    state_e          state_q;
    logic            ready_en_q;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     mem_word [DEPTH];
    logic [AW-1:0]   mem_addr [DEPTH];

    logic        empty, full, accept, push_in, push, pop, reload;
    logic        enc_legal;
    logic [31:0] enc_word, push_word;

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_mnem)
            5'd0:  enc_word = rtype(6'h04, in_rs, in_rt, in_rd);
            5'd1:  enc_word = rtype(6'h06, in_rs, in_rt, in_rd);
            5'd2:  enc_word = rtype(6'h07, in_rs, in_rt, in_rd);
            5'd3:  enc_word = rtype(6'h08, in_rs, 5'd0, 5'd0);
            5'd4:  enc_word = rtype(6'h20, in_rs, in_rt, in_rd);
            5'd5:  enc_word = rtype(6'h21, in_rs, in_rt, in_rd);
            5'd6:  enc_word = rtype(6'h22, in_rs, in_rt, in_rd);
            5'd7:  enc_word = rtype(6'h23, in_rs, in_rt, in_rd);
            5'd8:  enc_word = rtype(6'h24, in_rs, in_rt, in_rd);
            5'd9:  enc_word = rtype(6'h25, in_rs, in_rt, in_rd);
            5'd10: enc_word = rtype(6'h26, in_rs, in_rt, in_rd);
            5'd11: enc_word = rtype(6'h27, in_rs, in_rt, in_rd);
            5'd12: enc_word = {6'h02, in_target};
            5'd13: enc_word = itype(6'h04, in_rs, in_rt, in_imm);
            5'd14: enc_word = itype(6'h05, in_rs, in_rt, in_imm);
            5'd15: enc_word = itype(6'h06, in_rs, 5'd0, in_imm);
            5'd16: enc_word = itype(6'h07, in_rs, 5'd0, in_imm);
            5'd17: enc_word = itype(6'h08, in_rs, in_rt, in_imm);
            5'd18: enc_word = itype(6'h09, in_rs, in_rt, in_imm);
            5'd19: enc_word = itype(6'h0C, in_rs, in_rt, in_imm);
            5'd20: enc_word = itype(6'h0D, in_rs, in_rt, in_imm);
            5'd21: enc_word = itype(6'h0E, in_rs, in_rt, in_imm);
            5'd22: enc_word = itype(6'h23, in_rs, in_rt, in_imm);
            5'd23: enc_word = itype(6'h2B, in_rs, in_rt, in_imm);
            default: enc_legal = 1'b0;
        endcase
    end

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign in_ready  = ready_en_q & (state_q == StRun) & ~full;
    assign accept    = in_valid & in_ready;
    assign push_in   = accept & enc_legal;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign out_word  = mem_word[rptr_q];
    assign out_addr  = mem_addr[rptr_q];
    assign busy      = ~empty | (state_q != StRun);
    assign reload    = empty & ((state_q == StDrain) |
                                ((state_q == StRun) & restart & ~push_in));

`ifdef ENC_DELAY_SLOT_EN
    logic is_branch, pad_push, pend_q;
    assign is_branch = (in_mnem == 5'd3) | ((in_mnem >= 5'd12) & (in_mnem <= 5'd16));
    assign pad_push  = (state_q == StPad) & ~full;
    assign push      = push_in | pad_push;
    assign push_word = pad_push ? 32'h0 : enc_word;
`else
    assign push      = push_in;
    assign push_word = enc_word;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            mem_word[wptr_q] <= push_word;
            mem_addr[wptr_q] <= addr_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StRun;
            ready_en_q    <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
            addr_q        <= BASE_ADDR;
            illegal       <= 1'b0;
            illegal_count <= '0;
`ifdef ENC_DELAY_SLOT_EN
            pend_q        <= 1'b0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            illegal    <= accept & ~enc_legal;
            if (accept && !enc_legal && illegal_count != 8'hFF) begin
                illegal_count <= illegal_count + 8'd1;
            end
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
                addr_q <= addr_q + AW'(4);
            end else if (reload) begin
                addr_q <= BASE_ADDR;
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
            case (state_q)
                StRun: begin
`ifdef ENC_DELAY_SLOT_EN
                    if (push_in && is_branch) begin
                        state_q <= StPad;
                        pend_q  <= restart;
                    end else
`endif
                    // An accept alongside restart keeps the old address, then drains.
                    if (restart && (!empty || push_in)) state_q <= StDrain;
                end
`ifdef ENC_DELAY_SLOT_EN
                StPad: begin
                    if (!full) begin
                        state_q <= (pend_q || restart) ? StDrain : StRun;
                        pend_q  <= 1'b0;
                    end else if (restart) begin
                        pend_q <= 1'b1;
                    end
                end
`endif
                StDrain: if (empty) state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a table-driven encoding model.
module tb_instr_encoder;
    localparam int AW = 4;
    localparam int DEPTH = 4;
    localparam int BASE = 0;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [4:0]    in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_word;
    logic          illegal;
    logic [7:0]    illegal_count;
    logic          restart = 1'b0;
    logic          busy;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(4'h0)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_word(out_word), .illegal(illegal),
        .illegal_count(illegal_count), .restart(restart), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 0;
    int model_addr = BASE;
    int ill_cnt = 0;
    logic [31:0]   exp_word [$];
    logic [AW-1:0] exp_addr [$];

    int fn_tab [12] = '{'h04, 'h06, 'h07, 'h08, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27};
    int op_tab [11] = '{'h04, 'h05, 'h06, 'h07, 'h08, 'h09, 'h0C, 'h0D, 'h0E, 'h23, 'h2B};

    function automatic void ref_encode(input int m, input int rs, input int rt, input int rd,
                                       input int imm, input int tgt, output logic [31:0] w,
                                       output bit legal, output bit br);
        int r_t = rt;
        int r_d = rd;
        legal = (m < 24);
        br = 0;
        w = 32'h0;
        if (m < 12) begin
            if (m == 3) begin r_t = 0; r_d = 0; br = 1; end
            w = 32'((rs << 21) | (r_t << 16) | (r_d << 11) | fn_tab[m]);
        end else if (m == 12) begin
            w = 32'((2 << 26) | tgt);
            br = 1;
        end else if (m < 24) begin
            if (m == 15 || m == 16) r_t = 0;
            br = (m >= 13 && m <= 16);
            w = 32'((op_tab[m - 13] << 26) | (rs << 21) | (r_t << 16) | imm);
        end
    endfunction

    task automatic model_accept(input int m, input int rs, input int rt, input int rd,
                                input int imm, input int tgt);
        logic [31:0] w;
        bit legal, br;
        ref_encode(m, rs, rt, rd, imm, tgt, w, legal, br);
        if (legal) begin
            exp_word.push_back(w);
            exp_addr.push_back(AW'(model_addr));
            model_addr = (model_addr + 4) % (1 << AW);
`ifdef ENC_DELAY_SLOT_EN
            if (br) begin
                exp_word.push_back(32'h0);
                exp_addr.push_back(AW'(model_addr));
                model_addr = (model_addr + 4) % (1 << AW);
            end
`endif
        end else if (ill_cnt < 255) begin
            ill_cnt++;
        end
    endtask

    task automatic model_clear();
        exp_word.delete();
        exp_addr.delete();
        model_addr = BASE;
        ill_cnt = 0;
    endtask

    // Scoreboard: every pop must match the head of the expected stream.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_word.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got word %h addr %h, expected nothing",
                         out_word, out_addr);
            end else begin
                if (out_word !== exp_word[0] || out_addr !== exp_addr[0]) begin
                    errors++;
                    $display("FAIL pop_order: got %h@%h, expected %h@%h",
                             out_word, out_addr, exp_word[0], exp_addr[0]);
                end
                void'(exp_word.pop_front());
                void'(exp_addr.pop_front());
            end
        end
    end

    task automatic send(input int m, input int rs, input int rt, input int rd, input int imm,
                        input int tgt);
        bit ok = 0;
        in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            if (in_ready) ok = 1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: mnem %0d not accepted, in_ready %b, required 1", m, in_ready);
        end else begin
            model_accept(m, rs, rt, rd, imm, tgt);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (exp_word.size() != 0 || busy); i++) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (exp_word.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: %0d words still expected, busy %b, required 0",
                     exp_word.size(), busy);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, in_ready, illegal, busy} !== 4'b0 || illegal_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid/ready/illegal/busy %b%b%b%b count %0d, required 0",
                     out_valid, in_ready, illegal, busy, illegal_count);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 0", in_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int a;
        out_ready = 1'b1;
        send(4, 1, 2, 3, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h00221820 || out_addr !== 4'h0) begin
            errors++;
            $display("FAIL add_word: got %b %h@%h, required 1 00221820@0", out_valid, out_word, out_addr);
        end
        send(17, 1, 2, 0, 'hFFFF, 0);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h2022FFFF || out_addr !== 4'h4) begin
            errors++;
            $display("FAIL addi_word: got %b %h@%h, required 1 2022FFFF@4", out_valid, out_word, out_addr);
        end
        send(22, 29, 8, 0, 4, 0);
        checks++;
        if (out_word !== 32'h8FA80004) begin
            errors++;
            $display("FAIL lw_word: got %h, required 8FA80004", out_word);
        end
        send(3, 31, 5, 7, 0, 0);
        checks++;
        if (out_word !== 32'h03E00008) begin
            errors++;
            $display("FAIL jr_word: got %h, required 03E00008", out_word);
        end
        wait_idle();
        a = model_addr;
        send(12, 0, 0, 0, 0, 'h10);
        checks++;
        if (out_word !== 32'h08000010 || out_addr !== AW'(a)) begin
            errors++;
            $display("FAIL j_word: got %h@%h, required 08000010@%h", out_word, out_addr, AW'(a));
        end
`ifdef ENC_DELAY_SLOT_EN
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pad_ready: got %b, required 0", in_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_word !== 32'h0) begin
            errors++;
            $display("FAIL pad_nop: ready %b valid %b word %h, required 1 1 0", in_ready, out_valid, out_word);
        end
`else
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL j_ready: got %b, required 1", in_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL j_no_pad: out_valid %b, required 0", out_valid);
        end
`endif
        wait_idle();
    endtask

    task automatic test_illegal();
        int a = model_addr;
        out_ready = 1'b1;
        send(25, 1, 2, 3, 4, 5);
        checks++;
        if (illegal !== 1'b1 || illegal_count !== 8'(ill_cnt) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: illegal %b count %0d valid %b, required 1 %0d 0",
                     illegal, illegal_count, out_valid, ill_cnt);
        end
        @(posedge clock);
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_width: got %b, required 0", illegal);
        end
        send(5, 3, 4, 5, 0, 0);
        checks++;
        if (out_addr !== AW'(a)) begin
            errors++;
            $display("FAIL illegal_addr_reuse: got %h, required %h", out_addr, AW'(a));
        end
        wait_idle();
    endtask

    task automatic test_random();
        rand_rdy = 1;
        for (int n = 0; n < 80; n++) begin
            send(int'($urandom_range(0, 27)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, (1 << 26) - 1)));
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clock);
                #1;
            end
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        wait_idle();
        checks++;
        if (illegal_count !== 8'(ill_cnt)) begin
            errors++;
            $display("FAIL random_ill_count: got %0d, required %0d", illegal_count, ill_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) send(24 + (n % 8), 0, 0, 0, 0, 0);
        checks++;
        if (illegal_count !== 8'd255) begin
            errors++;
            $display("FAIL ill_saturate: got %0d, required 255", illegal_count);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) send(int'($urandom_range(4, 11)), n, n + 1, n + 2, 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_word !== exp_word[0]) begin
            errors++;
            $display("FAIL full_ready: ready %b word %h, required 0 %h", in_ready, out_word, exp_word[0]);
        end
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_same_cycle: ready %b, required 0", in_ready);
        end
        send(int'($urandom_range(17, 23)), 7, 8, 0, 'h1234, 0);
        wait_idle();
    endtask

    task automatic test_restart();
        int waited;
        out_ready = 1'b0;
        send(4, 1, 2, 3, 0, 0);
        send(6, 4, 5, 6, 0, 0);
        restart = 1'b1;
        @(posedge clock);
        #1 restart = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: busy %b ready %b, required 1 0", busy, in_ready);
        end
        out_ready = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clock);
            #1 waited++;
        end
        model_addr = BASE;
        checks++;
        if (in_ready !== 1'b1 || exp_word.size() != 0) begin
            errors++;
            $display("FAIL drain_exit: ready %b pending %0d, required 1 0", in_ready, exp_word.size());
        end
        send(8, 9, 10, 11, 0, 0);
        wait_idle();
        restart = 1'b1;
        send(18, 2, 3, 0, 'h55, 0);
        restart = 1'b0;
        model_addr = BASE;
        wait_idle();
        send(20, 1, 1, 0, 'h7, 0);
        wait_idle();
        restart = 1'b1;
        @(posedge clock);
        #1 restart = 1'b0;
        model_addr = BASE;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_restart: busy %b ready %b, required 0 1", busy, in_ready);
        end
        send(21, 3, 2, 0, 'h9, 0);
        wait_idle();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(9, 1, 2, 3, 0, 0);
        send(10, 4, 5, 6, 0, 0);
        send(30, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || illegal_count !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid %b count %0d busy %b ready %b, required 0 0 0 0",
                     out_valid, illegal_count, busy, in_ready);
        end
        model_clear();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b1;
        send(11, 5, 6, 7, 0, 0);
        checks++;
        if (out_addr !== 4'h0) begin
            errors++;
            $display("FAIL post_reset_addr: got %h, required 0", out_addr);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_saturation();
        test_back_to_back();
        test_restart();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Instruction encoder: the inverse of the control decoder. It turns a mnemonic ID plus operand fields into 32-bit MIPS instruction words.
- Buffers encoded words in a FIFO and tags each with a sequential instruction-memory address.
- Sits between the testbench/program loader and the instruction memory write port; generates programs for the datapath.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2).
- AW, 8, width of the address tag / address counter.
- BASE_ADDR, 0, counter value after reset or restart.

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request carries a valid instruction descriptor
- in_ready  out  1  encoder accepts the descriptor this cycle
- in_mnem  in  5  mnemonic ID (see Behaviour)
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump index
- out_valid  out  1  out_word/out_addr valid
- out_ready  in  1  sink consumes the word
- out_addr  out  AW  byte address of out_word
- out_word  out  32  encoded instruction
- illegal  out  1  one-cycle pulse: unsupported mnemonic dropped
- illegal_count  out  8  saturating count of dropped descriptors
- restart  in  1  reload address counter to BASE_ADDR
- busy  out  1  FIFO non-empty, or pad/restart pending

Behaviour:
- Reset (reset_n low, async): FIFO empty, out_valid=0, in_ready=0, illegal=0, illegal_count=0, addr counter=BASE_ADDR, state=RUN. in_ready may rise on the first edge after reset release.
- Mnemonic IDs 0..23, fn/op:
  - SLLV fn 04, SRLV 06, SRAV 07, JR 08, ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27 (hex). R-type = {000000, rs, rt, rd, 00000, fn}.
  - J op 02 = {op, target}.
  - BEQ 04, BNE 05, BLEZ 06, BGTZ 07, ADDI 08, ADDIU 09, ANDI 0C, ORI 0D, XORI 0E, LW 23, SW 2B (hex). I-type = {op, rs, rt, imm}.
  - IDs 24..31 are illegal.
- Field masking: shamt always 0. JR forces rt=rd=0. BLEZ/BGTZ force rt=0. Unused input fields are ignored.
- Accept: on in_valid & in_ready. A legal word is written into the FIFO at that edge, so out_valid is visible the next cycle (1-cycle latency). out_addr = counter value at enqueue; counter += 4 per enqueue, wrapping mod 2^AW.
- Illegal accept: nothing enqueued, counter unchanged. illegal=1 for exactly the next cycle. illegal_count +1, saturating at 255.
- in_ready = (state==RUN) & !full. There is no combinational path from out_ready. When full, a same-cycle pop does not raise in_ready until the next cycle.
- Output: stable while out_valid & !out_ready. Pop on out_valid & out_ready. Strict FIFO order.
- States:
  - RUN: normal accept.
  - PAD: only with the optional feature.
  - DRAIN: restart pending.
- restart handling:
  - In RUN with busy=0: counter reloads at the next edge.
  - With busy=1: go to DRAIN, in_ready=0, and reload the counter when the FIFO empties, then return to RUN.
  - restart in the same cycle as an accept: the accept is enqueued first with the old address, then the design goes to DRAIN.
- busy = !empty | (state!=RUN).
- reset_n asserted mid-operation: FIFO contents discarded immediately, all state returns to reset values.

Optional Feature:
- Macro: ENC_DELAY_SLOT_EN.
- Defined: after accepting J/JR/BEQ/BNE/BLEZ/BGTZ, go to PAD with in_ready=0. Enqueue NOP 0x00000000 at the next address when the FIFO is not full, then return to RUN (or DRAIN if restart arrived meanwhile). PAD holds while full.
- Undefined: no PAD state; branches and jumps are encoded alone.

Test Plan:
- ADD rs=1 rt=2 rd=3, then ADDI rs=1 rt=2 imm=FFFF, out_ready=1 -> 0x00221820 @0x00, then 0x2022FFFF @0x04, each one cycle after accept.
- LW rs=29 rt=8 imm=4; JR rs=31 rt=5 rd=7 -> 0x8FA80004, then 0x03E00008 (rt/rd masked).
- J target=0x10 with ENC_DELAY_SLOT_EN -> 0x08000010 @A, NOP 0x0 @A+4, in_ready=0 for one cycle. Without the macro: no NOP.
- in_mnem=25 -> illegal pulse 1 cycle, illegal_count=1, no out_valid, next legal word reuses the address. 300 illegal descriptors -> count=255.
- out_ready=0, push 5 words with DEPTH=4 -> in_ready=0 after the 4th. Release out_ready -> words in order, 5th accepted. With AW=4, addresses 0,4,8,C,0.
- restart with 2 words queued -> DRAIN, in_ready=0 until empty, next word @BASE_ADDR. reset_n low mid-stream -> out_valid=0 at once, count=0.
